// File: rtl/spi_slave_rx_mode3_if.sv
// Pin and parallel-output bundle for the mode-3 SPI receiver.
// The slave modport is the receiver's view; master is the pin driver / consumer view.
interface spi_slave_rx_mode3_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  In_spi_cs_n;
    logic                  In_spi_sclk;
    logic                  In_spi_mosi;
    logic [DATA_WIDTH-1:0] Out_rx_data;
    logic                  Out_rx_valid;
    logic                  Out_rx_busy;
    logic                  Out_frame_err;
    logic [7:0]            Out_rx_cnt;

    modport slave (
        input  In_spi_cs_n,
        input  In_spi_sclk,
        input  In_spi_mosi,
        output Out_rx_data,
        output Out_rx_valid,
        output Out_rx_busy,
        output Out_frame_err,
        output Out_rx_cnt
    );

    modport master (
        output In_spi_cs_n,
        output In_spi_sclk,
        output In_spi_mosi,
        input  Out_rx_data,
        input  Out_rx_valid,
        input  Out_rx_busy,
        input  Out_frame_err,
        input  Out_rx_cnt
    );
endinterface

// File: rtl/spi_slave_rx_mode3.sv
// SPI mode-3 (CPOL=1, CPHA=1) receiver oversampled by In_clk: MSB-first words,
// one-cycle valid strobe, abort detection and a saturating per-frame word count.
module spi_slave_rx_mode3 #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     In_clk,
    input  logic                     In_rst,
    spi_slave_rx_mode3_if.slave      bus_io
);
    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StActive = 1'b1;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_prev_q, sclk_prev_q;

    logic [0:0]            state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_busy_q, rx_busy_d;
    logic                  frame_err_q, frame_err_d;
    logic [7:0]            rx_cnt_q, rx_cnt_d;

    logic cs_s, sclk_s, mosi_s;
    logic sclk_rise, cs_fall, cs_rise;
    logic [DATA_WIDTH-1:0] shift_next;

    // New samples enter at bit 0; the oldest stage is the synchronised value.
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus_io.In_spi_cs_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus_io.In_spi_sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus_io.In_spi_mosi};
    end

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise  = sclk_s & ~sclk_prev_q & ~cs_s;
    assign cs_fall    = ~cs_s & cs_prev_q;
    assign cs_rise    = cs_s & ~cs_prev_q;
    assign shift_next = {shift_q[DATA_WIDTH-2:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_busy_d   = rx_busy_q;
        frame_err_d = 1'b0;
        rx_cnt_d    = rx_cnt_q;

        if (cs_fall) begin
            // A new frame always starts clean, even if a word was somehow in flight.
            state_d   = StActive;
            rx_busy_d = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
            rx_cnt_d  = 8'd0;
        end else if (cs_rise) begin
            state_d     = StIdle;
            rx_busy_d   = 1'b0;
            frame_err_d = (state_q == StActive) && (bit_cnt_q != '0);
            bit_cnt_d   = '0;
            shift_d     = '0;
        end else if (sclk_rise) begin
            if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                shift_d    = shift_next;
                rx_data_d  = shift_next;
                rx_valid_d = 1'b1;
                bit_cnt_d  = '0;
                if (rx_cnt_q != 8'hFF) begin
                    rx_cnt_d = rx_cnt_q + 8'd1;
                end
            end else begin
                shift_d   = shift_next;
                bit_cnt_d = bit_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge In_clk) begin
        if (In_rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_cnt_q    <= 8'd0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

    assign bus_io.Out_rx_data   = rx_data_q;
    assign bus_io.Out_rx_valid  = rx_valid_q;
    assign bus_io.Out_rx_busy   = rx_busy_q;
    assign bus_io.Out_frame_err = frame_err_q;
    assign bus_io.Out_rx_cnt    = rx_cnt_q;

endmodule

// File: tb/tb_spi_slave_rx_mode3.sv
// Directed bench for spi_slave_rx_mode3: drives mode-3 frames on the pins and checks
// the parallel outputs and strobe counts against hand-computed values.
module tb_spi_slave_rx_mode3;
    localparam int HALF = 10;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   valid_tot;
    int   err_tot;
    logic [7:0] vlog [0:31];

    spi_slave_rx_mode3_if #(.DATA_WIDTH(8)) bus ();

    spi_slave_rx_mode3 #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .In_clk(clk),
        .In_rst(rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Strobe monitor: every cycle a strobe is high counts once.
    initial begin
        valid_tot = 0;
        err_tot   = 0;
    end
    always @(posedge clk) begin
        if (bus.Out_rx_valid === 1'b1) begin
            vlog[valid_tot[4:0]] <= bus.Out_rx_data;
            valid_tot <= valid_tot + 1;
        end
        if (bus.Out_frame_err === 1'b1) begin
            err_tot <= err_tot + 1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.In_spi_sclk = 1'b0;
            bus.In_spi_mosi = b[7-i];
            wait_clk(HALF);
            bus.In_spi_sclk = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic cs_low();
        bus.In_spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        bus.In_spi_cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    int v0, e0, lat;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.In_spi_cs_n = 1'b1;
        bus.In_spi_sclk = 1'b1;
        bus.In_spi_mosi = 1'b0;
        wait_clk(3);

        chk("reset_data", 32'(bus.Out_rx_data), 32'h0);
        chk("reset_valid", 32'(bus.Out_rx_valid), 32'h0);
        chk("reset_busy", 32'(bus.Out_rx_busy), 32'h0);
        chk("reset_err", 32'(bus.Out_frame_err), 32'h0);
        chk("reset_cnt", 32'(bus.Out_rx_cnt), 32'h0);
        rst = 1'b0;
        wait_clk(5);

        // Single byte 0xA5, then measure busy release latency.
        v0 = valid_tot; e0 = err_tot;
        cs_low();
        send_bits(8'hA5, 8);
        wait_clk(HALF);
        chk("a5_busy_high", 32'(bus.Out_rx_busy), 32'h1);
        bus.In_spi_cs_n = 1'b1;
        lat = 0;
        while (bus.Out_rx_busy !== 1'b0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("a5_busy_latency", 32'(lat), 32'd3);
        wait_clk(2 * HALF);
        chk("a5_valid_pulses", 32'(valid_tot - v0), 32'd1);
        chk("a5_data", 32'(bus.Out_rx_data), 32'hA5);
        chk("a5_cnt", 32'(bus.Out_rx_cnt), 32'd1);
        chk("a5_err", 32'(err_tot - e0), 32'd0);

        // Two words in one frame.
        v0 = valid_tot; e0 = err_tot;
        cs_low();
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        cs_high();
        chk("two_valid_pulses", 32'(valid_tot - v0), 32'd2);
        chk("two_first", 32'(vlog[v0[4:0]]), 32'h3C);
        chk("two_second", 32'(vlog[5'(v0 + 1)]), 32'hC3);
        chk("two_cnt", 32'(bus.Out_rx_cnt), 32'd2);
        chk("two_err", 32'(err_tot - e0), 32'd0);

        // 0x5A, then a frame aborted after 5 bits, then 0x81.
        cs_low();
        send_bits(8'h5A, 8);
        cs_high();
        chk("pre_abort_data", 32'(bus.Out_rx_data), 32'h5A);
        v0 = valid_tot; e0 = err_tot;
        cs_low();
        send_bits(8'hE7, 5);
        cs_high();
        chk("abort_err_pulses", 32'(err_tot - e0), 32'd1);
        chk("abort_valid_pulses", 32'(valid_tot - v0), 32'd0);
        chk("abort_data_held", 32'(bus.Out_rx_data), 32'h5A);
        chk("abort_cnt", 32'(bus.Out_rx_cnt), 32'd0);
        e0 = err_tot;
        cs_low();
        send_bits(8'h81, 8);
        cs_high();
        chk("after_abort_data", 32'(bus.Out_rx_data), 32'h81);
        chk("after_abort_cnt", 32'(bus.Out_rx_cnt), 32'd1);
        chk("after_abort_err", 32'(err_tot - e0), 32'd0);

        // SCLK activity with CS_N high is ignored.
        v0 = valid_tot; e0 = err_tot;
        for (int i = 0; i < 16; i++) begin
            send_bits(8'($urandom_range(0, 255)), 1);
        end
        wait_clk(2 * HALF);
        chk("idle_sclk_valid", 32'(valid_tot - v0), 32'd0);
        chk("idle_sclk_err", 32'(err_tot - e0), 32'd0);
        chk("idle_sclk_cnt", 32'(bus.Out_rx_cnt), 32'd1);
        chk("idle_sclk_data", 32'(bus.Out_rx_data), 32'h81);
        chk("idle_sclk_busy", 32'(bus.Out_rx_busy), 32'h0);

        // Reset mid-frame after 4 bits of 0xFF.
        v0 = valid_tot; e0 = err_tot;
        cs_low();
        send_bits(8'hFF, 4);
        rst = 1'b1;
        wait_clk(1);
        chk("midrst_data", 32'(bus.Out_rx_data), 32'h0);
        chk("midrst_busy", 32'(bus.Out_rx_busy), 32'h0);
        chk("midrst_cnt", 32'(bus.Out_rx_cnt), 32'h0);
        chk("midrst_valid", 32'(bus.Out_rx_valid), 32'h0);
        chk("midrst_err", 32'(bus.Out_frame_err), 32'h0);
        rst = 1'b0;
        bus.In_spi_cs_n = 1'b1;
        bus.In_spi_sclk = 1'b1;
        wait_clk(2 * HALF);
        chk("midrst_no_strobes", 32'((valid_tot - v0) + (err_tot - e0)), 32'd0);
        cs_low();
        send_bits(8'h0F, 8);
        cs_high();
        chk("post_rst_data", 32'(bus.Out_rx_data), 32'h0F);
        chk("post_rst_cnt", 32'(bus.Out_rx_cnt), 32'd1);

        // Back-to-back frames with a short CS_N-high gap.
        v0 = valid_tot; e0 = err_tot;
        cs_low();
        send_bits(8'h00, 8);
        wait_clk(HALF);
        bus.In_spi_cs_n = 1'b1;
        wait_clk(4 * HALF);
        chk("b2b_first_data", 32'(bus.Out_rx_data), 32'h00);
        chk("b2b_first_cnt", 32'(bus.Out_rx_cnt), 32'd1);
        cs_low();
        send_bits(8'hFF, 8);
        cs_high();
        chk("b2b_second_data", 32'(bus.Out_rx_data), 32'hFF);
        chk("b2b_second_cnt", 32'(bus.Out_rx_cnt), 32'd1);
        chk("b2b_valid_pulses", 32'(valid_tot - v0), 32'd2);
        chk("b2b_log0", 32'(vlog[v0[4:0]]), 32'h00);
        chk("b2b_log1", 32'(vlog[5'(v0 + 1)]), 32'hFF);
        chk("b2b_err", 32'(err_tot - e0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
